cache_trace_driver: RTL and testbench
=====================================

// Module: cache_trace_driver
// PURPOSE
// - Address-trace source for the cache model: the initiator that feeds cache_top its cache_addr stream.
// - Holds a loadable trace RAM of {op, addr} entries and replays it as a valid/ready request stream, once or looping.
// - Counts issued reads/writes and stall cycles so bench and top level can check them against cache-side counters.
// PARAMETERS
// - ADDR_W      48   request address width; matches cache_addr
// - DEPTH_LOG2  10   trace RAM holds 2**DEPTH_LOG2 entries
// - CNT_W       12   width of the issued-read/issued-write counters; matches cache_top num_reads/num_writes
// PORTS
// - clk          in   1         clock
// - reset        in   1         synchronous, active-high
// - load_en      in   1         write one trace entry this cycle; honoured only in IDLE
// - load_idx     in   DEPTH_LOG2  trace RAM write index
// - load_addr    in   ADDR_W    entry address
// - load_wr      in   1         entry op: 1 = write, 0 = read
// - trace_len    in   DEPTH_LOG2+1  number of entries to replay; sampled on start
// - loop_en      in   1         1 = wrap to entry 0 after the last entry; sampled on start
// - start        in   1         one-cycle pulse; begin replay from entry 0
// - stop         in   1         abort replay after the current handshake, or immediately if none is pending
// - req_valid    out  1         request presented
// - req_ready    in   1         cache accepts the request
// - req_addr     out  ADDR_W    request address
// - req_write    out  1         request op
// - busy         out  1         replay in progress (FETCH or ISSUE)
// - done         out  1         one-cycle pulse when replay ends (normally or by stop)
// - num_rd       out  CNT_W     reads accepted since start
// - num_wr       out  CNT_W     writes accepted since start
// - stall_cyc    out  16        cycles with req_valid=1 and req_ready=0 since start
// BEHAVIOUR
// - Reset: state=IDLE; req_valid=0, req_addr=0, req_write=0, busy=0, done=0, num_rd=num_wr=stall_cyc=0, ptr=0.
//   Trace RAM contents are not cleared.
// - States: IDLE -> FETCH -> ISSUE -> (FETCH | DONE) -> IDLE.
// - IDLE: load_en writes RAM[load_idx]. On start: latch trace_len and loop_en, clear ptr and all counters.
//   Go to DONE if trace_len==0, otherwise to FETCH. If start and load_en coincide, start wins and the write is dropped.
// - FETCH: RAM read of ptr has 1-cycle latency. The next cycle enters ISSUE with req_addr/req_write loaded
//   and req_valid=1. Latency from the start pulse to the first req_valid is 2 cycles.
// - ISSUE: req_valid, req_addr and req_write are held stable until req_ready=1.
//   - Each cycle with valid && !ready increments stall_cyc, saturating at 16'hFFFF.
//   - On handshake: increment num_wr or num_rd, saturating at 2**CNT_W-1; ptr++.
//   - Next state after a handshake: DONE if ptr+1==len and !loop; FETCH with ptr=0 if ptr+1==len and loop;
//     FETCH otherwise. The handshake cycle deasserts req_valid next cycle, so there is one bubble per entry.
// - stop:
//   - In FETCH: go to DONE.
//   - In ISSUE without ready: keep req_valid until the handshake, then go to DONE.
//   - In ISSUE with ready in the same cycle: the handshake counts, then DONE.
//   - In IDLE: ignored.
// - DONE: done=1 for exactly one cycle, req_valid=0, return to IDLE. Counters hold until the next start.
// - start while busy is ignored. load_en outside IDLE is ignored.
// - busy=1 exactly in FETCH and ISSUE.
// - Reset mid-ISSUE drops req_valid on the next edge without completing the handshake; counters clear.
// STRUCTURE
// - cache_pkg: ADDR_W constant, state enum {IDLE, FETCH, ISSUE, DONE}, trace entry struct {logic wr; logic [ADDR_W-1:0] addr}.
// - Sub-module trace_ram: single write port, synchronous read with 1-cycle latency, no reset, width ADDR_W+1.
// - Top level holds the FSM, ptr, the latched len/loop values, the output registers and the saturating counters.
// TESTING
// - Load 3 entries (R 0x40, W 0x80, R 0x1000), len=3, ready=1 -> 3 handshakes in that order,
//   num_rd=2, num_wr=1, stall_cyc=0, done pulses once, first valid 2 cycles after start.
// - Same trace, ready low for 5 cycles on entry 1 -> req_addr stays 0x80 for those 5 cycles, stall_cyc=5, counts unchanged.
// - len=2, loop=1, stop asserted after the 5th handshake -> addresses A0,A1,A0,A1,A0, then done; num_rd+num_wr=5.
// - len=0 start -> no req_valid, done 1 cycle after start, counters 0.
// - Reset asserted while req_valid=1 and ready=0 -> req_valid=0 and counters=0 on the next cycle;
//   a later start replays from entry 0.
// - start while busy, and load_en while busy -> replay unaffected, RAM contents unchanged (checked by a second replay).

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache model: request address width, trace-driver FSM
// states and the {op, addr} trace entry layout.
package cache_pkg;

  localparam int ADDR_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port, one registered read port, no reset so it
// maps onto block RAM.
module trace_ram #(
  parameter int WIDTH      = 49,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_trace_driver.sv
// Replays a loaded {op, addr} trace as a valid/ready request stream for the
// cache, once or looping, and counts accepted reads/writes and stall cycles.
module cache_trace_driver #(
  parameter int ADDR_W     = cache_pkg::ADDR_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_idx,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic                  load_wr,
  input  logic [DEPTH_LOG2:0]   trace_len,
  input  logic                  loop_en,
  input  logic                  start,
  input  logic                  stop,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_W-1:0]     req_addr,
  output logic                  req_write,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      num_rd,
  output logic [CNT_W-1:0]      num_wr,
  output logic [15:0]           stall_cyc
);
  import cache_pkg::*;

  localparam int LEN_W = DEPTH_LOG2 + 1;

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] ptr_reg, ptr_next;
  logic [LEN_W-1:0]      len_reg, len_next;
  logic                  loop_reg, loop_next;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  req_valid_reg, req_valid_next;
  logic                  req_write_reg, req_write_next;
  logic [ADDR_W-1:0]     req_addr_reg, req_addr_next;
  logic [CNT_W-1:0]      num_rd_reg, num_rd_next;
  logic [CNT_W-1:0]      num_wr_reg, num_wr_next;
  logic [15:0]           stall_reg, stall_next;

  logic                  ram_we;
  logic [ADDR_W:0]       rd_data;
  logic                  last_entry;

  // The RAM is addressed with ptr_next so the entry is already on rd_data
  // during FETCH and can be registered into the request on the FETCH->ISSUE edge.
  trace_ram #(
    .WIDTH      (ADDR_W + 1),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_trace_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (load_idx),
    .wdata ({load_wr, load_addr}),
    .raddr (ptr_next),
    .rdata (rd_data)
  );

  assign last_entry = ({1'b0, ptr_reg} + LEN_W'(1)) == len_reg;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    len_next       = len_reg;
    loop_next      = loop_reg;
    stop_pend_next = stop_pend_reg;
    req_valid_next = req_valid_reg;
    req_write_next = req_write_reg;
    req_addr_next  = req_addr_reg;
    num_rd_next    = num_rd_reg;
    num_wr_next    = num_wr_reg;
    stall_next     = stall_reg;
    ram_we         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next       = trace_len;
          loop_next      = loop_en;
          ptr_next       = '0;
          stop_pend_next = 1'b0;
          num_rd_next    = '0;
          num_wr_next    = '0;
          stall_next     = '0;
          state_next     = (trace_len == '0) ? DONE : FETCH;
        end else if (load_en) begin
          ram_we = 1'b1;
        end
      end

      FETCH: begin
        if (stop) begin
          state_next = DONE;
        end else begin
          state_next     = ISSUE;
          req_valid_next = 1'b1;
          req_addr_next  = rd_data[ADDR_W-1:0];
          req_write_next = rd_data[ADDR_W];
        end
      end

      ISSUE: begin
        if (!req_ready) begin
          if (stall_reg != 16'hFFFF) stall_next = stall_reg + 16'd1;
          if (stop) stop_pend_next = 1'b1;
        end else begin
          req_valid_next = 1'b0;
          stop_pend_next = 1'b0;
          if (req_write_reg) begin
            if (num_wr_reg != '1) num_wr_next = num_wr_reg + CNT_W'(1);
          end else begin
            if (num_rd_reg != '1) num_rd_next = num_rd_reg + CNT_W'(1);
          end
          ptr_next = last_entry ? '0 : ptr_reg + DEPTH_LOG2'(1);
          // A stop seen while stalled still lets this handshake count.
          if (stop || stop_pend_reg || (last_entry && !loop_reg)) begin
            state_next = DONE;
          end else begin
            state_next = FETCH;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      len_reg       <= '0;
      loop_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      req_valid_reg <= 1'b0;
      req_write_reg <= 1'b0;
      req_addr_reg  <= '0;
      num_rd_reg    <= '0;
      num_wr_reg    <= '0;
      stall_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      len_reg       <= len_next;
      loop_reg      <= loop_next;
      stop_pend_reg <= stop_pend_next;
      req_valid_reg <= req_valid_next;
      req_write_reg <= req_write_next;
      req_addr_reg  <= req_addr_next;
      num_rd_reg    <= num_rd_next;
      num_wr_reg    <= num_wr_next;
      stall_reg     <= stall_next;
    end
  end

  assign req_valid = req_valid_reg;
  assign req_addr  = req_addr_reg;
  assign req_write = req_write_reg;
  assign busy      = (state_reg == FETCH) || (state_reg == ISSUE);
  assign done      = (state_reg == DONE);
  assign num_rd    = num_rd_reg;
  assign num_wr    = num_wr_reg;
  assign stall_cyc = stall_reg;

endmodule

// File: tb/tb_cache_trace_driver.sv
// Bench for cache_trace_driver: table of replay scenarios checked against a
// request scoreboard, plus reset-during-issue as a hand-written sequence.
`timescale 1ns/1ps
module tb_cache_trace_driver;
  import cache_pkg::*;

  localparam int DEPTH_LOG2 = 10;
  localparam int CNT_W      = 12;
  localparam int LEN_W      = DEPTH_LOG2 + 1;
  localparam int BUDGET     = 100;
  localparam int NVEC       = 7;

  typedef struct {
    int len;
    int loop;
    int stall_hs;    // handshake index whose request is held off, -1 = none
    int stall_len;
    int stop_after;  // stop pulsed with this handshake number, 0 = none
    int disturb;     // start + load_en pulsed while busy
    int exp_hs;
    int exp_rd;
    int exp_wr;
    int exp_stall;
    int exp_done;    // cycle (counted from the start edge) on which done is seen
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset, load_en, load_wr, loop_en, start, stop, req_ready;
  logic [DEPTH_LOG2-1:0] load_idx;
  logic [ADDR_W-1:0]     load_addr;
  logic [LEN_W-1:0]      trace_len;
  logic                  req_valid, req_write, busy, done;
  logic [ADDR_W-1:0]     req_addr;
  logic [CNT_W-1:0]      num_rd, num_wr;
  logic [15:0]           stall_cyc;

  int           vec_cnt = 0;
  int           err_cnt = 0;
  trace_entry_t trace_tb [3];
  trace_entry_t exp_q [$];
  vec_t         vecs [NVEC];

  always #5 clk = ~clk;

  cache_trace_driver #(
    .ADDR_W     (ADDR_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_addr (load_addr),
    .load_wr   (load_wr),
    .trace_len (trace_len),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .busy      (busy),
    .done      (done),
    .num_rd    (num_rd),
    .num_wr    (num_wr),
    .stall_cyc (stall_cyc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted request must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_req: got addr 0x%0h, want no request", req_addr);
      end else begin
        trace_entry_t e;
        e = exp_q.pop_front();
        check("req_addr", 64'(req_addr), 64'(e.addr));
        check("req_write", 64'(req_write), 64'(e.wr));
        $display("  handshake addr=0x%0h wr=%0b", req_addr, req_write);
      end
    end
  end

  task automatic load_entry(input int idx, input trace_entry_t e);
    @(posedge clk); #1;
    load_en   = 1'b1;
    load_idx  = DEPTH_LOG2'(idx);
    load_addr = e.addr;
    load_wr   = e.wr;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc, hs, stalled, first_valid, done_cyc;
    bit   finished;
    v = vecs[i];
    for (int k = 0; k < v.exp_hs; k++) exp_q.push_back(trace_tb[k % v.len]);

    @(posedge clk); #1;
    trace_len = LEN_W'(v.len);
    loop_en   = (v.loop != 0);
    start     = 1'b1;
    // A write coinciding with start must be dropped.
    load_en   = 1'b1;
    load_idx  = DEPTH_LOG2'(2);
    load_addr = ADDR_W'(48'hBAD);
    load_wr   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    load_en = 1'b0;

    cyc = 1; hs = 0; stalled = 0; first_valid = -1; done_cyc = -1; finished = 0;
    while (!finished && cyc < BUDGET) begin
      req_ready = !(req_valid && hs == v.stall_hs && stalled < v.stall_len);
      stop      = req_valid && req_ready && (hs + 1 == v.stop_after);
      start     = (v.disturb != 0) && cyc == 3;
      load_en   = (v.disturb != 0) && cyc == 3;
      load_idx  = '0;
      load_addr = ADDR_W'(48'hBAD);
      trace_len = (v.disturb != 0) ? LEN_W'(1) : LEN_W'(v.len);
      @(negedge clk);
      if (req_valid && first_valid < 0) first_valid = cyc;
      if (req_valid && !req_ready) begin
        stalled++;
        if (exp_q.size() > 0) check("stall_addr_hold", 64'(req_addr), 64'(exp_q[0].addr));
      end
      if (req_valid && req_ready) hs++;
      if (done) begin
        finished = 1;
        done_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_ready = 1'b0; stop = 1'b0; start = 1'b0; load_en = 1'b0;

    check("done_seen", 64'(finished), 64'(1));
    check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
    if (v.exp_hs > 0) check("first_valid_lat", 64'(first_valid), 64'(2));
    check("handshakes", 64'(hs), 64'(v.exp_hs));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
    check("num_rd", 64'(num_rd), 64'(v.exp_rd));
    check("num_wr", 64'(num_wr), 64'(v.exp_wr));
    check("stall_cyc", 64'(stall_cyc), 64'(v.exp_stall));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    $display("vector %0d: len=%0d loop=%0d hs=%0d rd=%0d wr=%0d stall=%0d done_cyc=%0d",
             i, v.len, v.loop, hs, num_rd, num_wr, stall_cyc, done_cyc);
  endtask

  initial begin
    int w;
    trace_tb[0] = '{wr: 1'b0, addr: ADDR_W'(48'h40)};
    trace_tb[1] = '{wr: 1'b1, addr: ADDR_W'(48'h80)};
    trace_tb[2] = '{wr: 1'b0, addr: ADDR_W'(48'h1000)};

    //             len loop stall_hs stall_len stop dist  hs  rd  wr  stall done
    vecs[0] = '{len: 3, loop: 0, stall_hs: -1, stall_len: 0, stop_after: 0, disturb: 0,
                exp_hs: 3, exp_rd: 2, exp_wr: 1, exp_stall: 0, exp_done: 7};
    vecs[1] = '{len: 3, loop: 0, stall_hs: 1, stall_len: 5, stop_after: 0, disturb: 0,
                exp_hs: 3, exp_rd: 2, exp_wr: 1, exp_stall: 5, exp_done: 12};
    vecs[2] = '{len: 2, loop: 1, stall_hs: -1, stall_len: 0, stop_after: 5, disturb: 0,
                exp_hs: 5, exp_rd: 3, exp_wr: 2, exp_stall: 0, exp_done: 11};
    vecs[3] = '{len: 0, loop: 0, stall_hs: -1, stall_len: 0, stop_after: 0, disturb: 0,
                exp_hs: 0, exp_rd: 0, exp_wr: 0, exp_stall: 0, exp_done: 1};
    vecs[4] = '{len: 1, loop: 0, stall_hs: 0, stall_len: 2, stop_after: 0, disturb: 0,
                exp_hs: 1, exp_rd: 1, exp_wr: 0, exp_stall: 2, exp_done: 5};
    vecs[5] = '{len: 3, loop: 0, stall_hs: -1, stall_len: 0, stop_after: 0, disturb: 1,
                exp_hs: 3, exp_rd: 2, exp_wr: 1, exp_stall: 0, exp_done: 7};
    vecs[6] = '{len: 3, loop: 0, stall_hs: -1, stall_len: 0, stop_after: 0, disturb: 0,
                exp_hs: 3, exp_rd: 2, exp_wr: 1, exp_stall: 0, exp_done: 7};

    reset = 1'b1; load_en = 1'b0; load_wr = 1'b0; loop_en = 1'b0; start = 1'b0;
    stop = 1'b0; req_ready = 1'b0; load_idx = '0; load_addr = '0; trace_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_valid", 64'(req_valid), 64'(0));
    check("reset_req_addr", 64'(req_addr), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_counts", 64'({num_rd, num_wr, stall_cyc}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int k = 0; k < 3; k++) load_entry(k, trace_tb[k]);
    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Reset while a request is stalled, then replay from entry 0.
    @(posedge clk); #1;
    trace_len = LEN_W'(3); loop_en = 1'b0; start = 1'b1; req_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!req_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    check("pre_reset_valid", 64'(req_valid), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_stall", 64'(stall_cyc), 64'(2));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_req_valid", 64'(req_valid), 64'(0));
    check("midreset_stall", 64'(stall_cyc), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    $display("reset during issue: valid=%0b stall=%0d busy=%0b", req_valid, stall_cyc, busy);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
